// File: rtl/frame_pkg.sv
// frame_pkg: shared frame-buffer geometry and types for frame_fetch and frame_write
package frame_pkg;

    // Words per frame (640x480 RGB565)
    localparam int FRAME_WORDS  = 307200;
    // Word distance between frame blocks; block b starts at b*BLOCK_STRIDE
    localparam int BLOCK_STRIDE = 2**19;

    typedef logic [1:0] block_num_t;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN
    } fetch_state_e;

    // Newest completed block is the one just behind the block being written
    function automatic block_num_t prev_block(input block_num_t b);
        return b - 2'd1;
    endfunction

endpackage

// File: rtl/sc_fifo.sv
// sc_fifo: single-clock FIFO with occupancy count and synchronous flush
module sc_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic                       clk,
    input  logic                       rest_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [DATA_W-1:0]          din,
    input  logic                       pop,
    output logic [DATA_W-1:0]          dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_en;
    logic              rd_en;

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle
    always_comb begin
        rd_en = pop && count != '0;
        wr_en = push && (count != CW'(DEPTH) || rd_en);
        dout  = mem[rd_ptr];
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= din;
    end

    // Pointers and occupancy; flush wins over a simultaneous push or pop
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_en);
            rd_ptr <= rd_ptr + AW'(rd_en);
            count  <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

endmodule

// File: rtl/frame_fetch.sv
// frame_fetch: Avalon-MM read master streaming the newest completed frame block to the pixel path
module frame_fetch #(
    parameter int ADDR_W       = 24,
    parameter int DATA_W       = 16,
    parameter int FRAME_WORDS  = frame_pkg::FRAME_WORDS,
    parameter int BLOCK_STRIDE = frame_pkg::BLOCK_STRIDE,
    parameter int FIFO_DEPTH   = 256,
    parameter int MAX_OUTST    = 8
) (
    input  logic              clk,
    input  logic              rest_n,
    input  logic              frame_start,
    input  logic [1:0]        write_block_num,
    output logic [1:0]        read_block_num,
    output logic [ADDR_W-1:0] avl_m0_address,
    output logic              avl_m0_read,
    input  logic              avl_m0_waitrequest,
    input  logic [DATA_W-1:0] avl_m0_readdata,
    input  logic              avl_m0_readdatavalid,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_last,
    output logic              underflow
);

    import frame_pkg::*;

    localparam int CW  = $clog2(FRAME_WORDS+1);
    localparam int OW  = $clog2(MAX_OUTST+1);
    localparam int FCW = $clog2(FIFO_DEPTH+1);

    fetch_state_e      state;
    fetch_state_e      state_n;
    logic [CW-1:0]     cmd_cnt;
    logic [CW-1:0]     cmd_cnt_n;
    logic [CW-1:0]     pop_cnt;
    logic [CW-1:0]     pop_cnt_n;
    logic [OW-1:0]     outst;
    logic [OW-1:0]     outst_n;
    logic [FCW-1:0]    fifo_count;
    logic [FCW-1:0]    fifo_count_n;
    block_num_t        blk_n;
    logic              rdv_q;
    logic [DATA_W-1:0] rd_q;
    logic              accept;
    logic              held;
    logic              pop;
    logic              last_pop;
    logic              restart;
    logic              start;
    logic              capture;
    logic              read_n;
    logic [ADDR_W-1:0] addr_n;
    logic              underflow_n;

    // Next-state and next-output logic; read/address are registered, so the issue
    // decision is made on the counter values that will hold in the following cycle
    always_comb begin
        accept       = avl_m0_read && !avl_m0_waitrequest;
        held         = avl_m0_read && avl_m0_waitrequest;
        pix_valid    = state == ACTIVE && fifo_count != '0;
        pix_last     = pix_valid && pop_cnt == CW'(FRAME_WORDS-1);
        pop          = pix_valid && pix_ready;
        last_pop     = pop && pop_cnt == CW'(FRAME_WORDS-1);
        restart      = state == ACTIVE && frame_start;
        start        = (state == IDLE && frame_start) ||
                       (state == DRAIN && outst == '0 && !avl_m0_read);
        capture      = avl_m0_readdatavalid && state == ACTIVE && !restart;
        state_n      = start ? ACTIVE : restart ? DRAIN : last_pop ? IDLE : state;
        blk_n        = start ? prev_block(write_block_num) : read_block_num;
        cmd_cnt_n    = (start || restart) ? '0 : cmd_cnt + CW'(accept);
        pop_cnt_n    = (start || restart) ? '0 : pop_cnt + CW'(pop);
        outst_n      = outst + OW'(accept) - OW'(avl_m0_readdatavalid);
        fifo_count_n = restart ? '0 : fifo_count + FCW'(rdv_q) - FCW'(pop);
        // Credit counts every word that is in flight, in the input register or buffered
        read_n       = held || (state_n == ACTIVE && !restart &&
                       int'(cmd_cnt_n) < FRAME_WORDS &&
                       int'(outst_n) < MAX_OUTST &&
                       int'(fifo_count_n) + int'(capture) + int'(outst_n) < FIFO_DEPTH);
        addr_n       = held ? avl_m0_address :
                       ADDR_W'(BLOCK_STRIDE * int'(blk_n) + int'(cmd_cnt_n));
        underflow_n  = underflow || (state == ACTIVE && pix_ready &&
                       fifo_count == '0 && int'(pop_cnt) < FRAME_WORDS);
    end

    // Fetch FSM, counters, block latch, registered bus outputs and response register
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            state          <= IDLE;
            cmd_cnt        <= '0;
            pop_cnt        <= '0;
            outst          <= '0;
            read_block_num <= '0;
            avl_m0_read    <= 1'b0;
            avl_m0_address <= '0;
            underflow      <= 1'b0;
            rdv_q          <= 1'b0;
            rd_q           <= '0;
        end else begin
            state          <= state_n;
            cmd_cnt        <= cmd_cnt_n;
            pop_cnt        <= pop_cnt_n;
            outst          <= outst_n;
            read_block_num <= blk_n;
            avl_m0_read    <= read_n;
            avl_m0_address <= addr_n;
            underflow      <= underflow_n;
            rdv_q          <= capture;
            rd_q           <= avl_m0_readdata;
        end
    end

    sc_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rest_n (rest_n),
        .flush  (restart),
        .push   (rdv_q),
        .din    (rd_q),
        .pop    (pop),
        .dout   (pix_data),
        .count  (fifo_count)
    );

endmodule

// File: tb/tb_frame_fetch.sv
// tb_frame_fetch: directed tests of frame_fetch against a scoreboard of frame words
module tb_frame_fetch;

    localparam int FW     = 64;
    localparam int FD     = 16;
    localparam int MO     = 8;
    localparam int STRIDE = 2**19;

    typedef enum {M_IDLE, M_ACT, M_DRAIN} mode_t;

    logic        clk = 1'b0;
    logic        rest_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [1:0]  wbn = 2'd1;
    logic        wr = 1'b0;
    logic        rdv = 1'b0;
    logic [15:0] rdata = '0;
    logic        pix_ready = 1'b0;
    logic [1:0]  rbn;
    logic [23:0] addr;
    logic        rd;
    logic        pv;
    logic [15:0] pd;
    logic        pl;
    logic        uf;

    int passed = 0;
    int total = 0;

    int lat = 1;
    int wprob = 0;
    int rdy_mode = 2;
    logic fs_req = 1'b0;

    mode_t       mode = M_IDLE;
    int          cyc = 0;
    int          cmd_i = 0;
    int          rsp_i = 0;
    int          pop_i = 0;
    int          outst = 0;
    int          discard = 0;
    int          owed = 0;
    int          frames_done = 0;
    int          first_rsp_cyc = 0;
    bit          first_pix_seen = 0;
    bit          prev_held = 0;
    logic [23:0] prev_addr = '0;
    logic [23:0] exp_base = '0;
    logic [23:0] new_base = '0;
    logic [1:0]  exp_blk = '0;
    logic [1:0]  new_blk = '0;
    logic [23:0] q_addr[$];
    int          q_due[$];

    always #5 clk = ~clk;

    frame_fetch #(
        .ADDR_W       (24),
        .DATA_W       (16),
        .FRAME_WORDS  (FW),
        .BLOCK_STRIDE (STRIDE),
        .FIFO_DEPTH   (FD),
        .MAX_OUTST    (MO)
    ) dut (
        .clk                  (clk),
        .rest_n               (rest_n),
        .frame_start          (frame_start),
        .write_block_num      (wbn),
        .read_block_num       (rbn),
        .avl_m0_address       (addr),
        .avl_m0_read          (rd),
        .avl_m0_waitrequest   (wr),
        .avl_m0_readdata      (rdata),
        .avl_m0_readdatavalid (rdv),
        .pix_valid            (pv),
        .pix_ready            (pix_ready),
        .pix_data             (pd),
        .pix_last             (pl),
        .underflow            (uf)
    );

    function automatic logic [15:0] memdata(input logic [23:0] a);
        return a[15:0] ^ 16'hA5C3 ^ {8'h00, a[23:16]};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic new_frame(input logic [1:0] blk);
        exp_blk = blk;
        exp_base = 24'(STRIDE * int'(blk));
        cmd_i = 0;
        rsp_i = 0;
        pop_i = 0;
        first_pix_seen = 0;
    endtask

    // Slave, consumer and scoreboard: check outputs, drive inputs for the next edge, book its events
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rest_n) begin
            mode = M_IDLE;
            outst = 0;
            prev_held = 0;
            q_addr.delete();
            q_due.delete();
            wr = 0;
            rdv = 0;
            frame_start = 0;
            pix_ready = 0;
            continue;
        end
        if (prev_held) begin
            chk("hold_read", rd, 1);
            chk("hold_addr", addr, prev_addr);
        end else if (rd) begin
            if (mode == M_DRAIN) begin
                chk("drain_exit_outst", outst, 0);
                chk("drain_discards", discard, owed);
                mode = M_ACT;
                new_frame(new_blk);
            end
            chk("read_while_active", mode == M_ACT, 1);
            chk("cmd_addr", addr, 24'(exp_base + 24'(cmd_i)));
        end
        if (mode == M_ACT) chk("read_block_num", rbn, exp_blk);
        if (pv) begin
            chk("pix_in_active", mode == M_ACT, 1);
            chk("pix_has_data", rsp_i > pop_i, 1);
            chk("pix_data", pd, memdata(24'(exp_base + 24'(pop_i))));
            chk("pix_last", pl, pop_i == FW - 1);
            if (!first_pix_seen) begin
                chk("pix_latency", cyc >= first_rsp_cyc + 2, 1);
                first_pix_seen = 1;
            end
        end else begin
            chk("pix_last_idle", pl, 0);
        end
        frame_start = fs_req;
        wr = $urandom_range(99) < wprob;
        rdv = 0;
        if (q_due.size() > 0 && q_due[0] <= cyc) begin
            rdv = 1;
            rdata = memdata(q_addr[0]);
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
        pix_ready = rdy_mode == 1 || (rdy_mode == 2 && pv);
        if (rd && !wr) begin
            q_addr.push_back(addr);
            q_due.push_back(cyc + lat);
            outst++;
            chk("outst_max", outst <= MO, 1);
            if (mode == M_ACT) begin
                cmd_i++;
                chk("credit", cmd_i - pop_i <= FD, 1);
            end else if (mode == M_DRAIN) begin
                owed++;
            end
        end
        if (rdv) begin
            outst--;
            if (mode == M_ACT && !frame_start) begin
                if (rsp_i == 0) first_rsp_cyc = cyc;
                rsp_i++;
            end else if (mode == M_DRAIN) begin
                discard++;
            end
        end
        if (pv && pix_ready) begin
            pop_i++;
            if (pop_i == FW) begin
                frames_done++;
                if (!frame_start) mode = M_IDLE;
            end
        end
        if (frame_start) begin
            if (mode == M_IDLE) begin
                mode = M_ACT;
                new_frame(wbn - 2'd1);
            end else if (mode == M_ACT) begin
                mode = M_DRAIN;
                owed = outst;
                discard = 0;
                new_blk = wbn - 2'd1;
            end
        end
        prev_held = rd && wr;
        prev_addr = addr;
    end

    task automatic pulse_fs();
        @(posedge clk);
        #1 fs_req = 1;
        @(posedge clk);
        #1 fs_req = 0;
    endtask

    task automatic wait_done();
        int f0;
        f0 = frames_done;
        for (int i = 0; i < 3000 && frames_done == f0; i++) @(posedge clk);
        #1;
        chk("frame_done", frames_done, f0 + 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_read"}, rd, 0);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_pix_valid"}, pv, 0);
        chk({tag, "_pix_last"}, pl, 0);
        chk({tag, "_rbn"}, rbn, 0);
        chk({tag, "_underflow"}, uf, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        rest_n = 1;
        repeat (2) @(posedge clk);

        // Zero-wait slave, 1-cycle latency, consumer always taking available pixels
        wbn = 2'd1; lat = 1; wprob = 0; rdy_mode = 2;
        pulse_fs();
        chk("t1_rbn", rbn, 0);
        chk("t1_first_addr", addr, 24'h000000);
        wait_done();
        chk("t1_cmds", cmd_i, 64);
        chk("t1_pops", pop_i, 64);
        chk("t1_underflow", uf, 0);
        chk("t1_read_off", rd, 0);

        // Block wrap-around selection, random stalls, longer latency
        wbn = 2'd0; lat = 5; wprob = 50;
        pulse_fs();
        chk("t2_rbn", rbn, 3);
        chk("t2_first_addr", addr, 24'h180000);
        chk("t2_read", rd, 1);
        wait_done();
        chk("t2_pops", pop_i, 64);

        // Consumer stalled: issue stops at full credit, nothing lost after release
        wbn = 2'd3; lat = 1; wprob = 0; rdy_mode = 0;
        pulse_fs();
        repeat (200) @(posedge clk);
        #1;
        chk("t4_cmds_at_full", cmd_i, FD);
        chk("t4_read_stopped", rd, 0);
        chk("t4_pix_valid", pv, 1);
        chk("t4_rbn", rbn, 2);
        rdy_mode = 2;
        wait_done();
        chk("t4_pops", pop_i, 64);

        // Restart mid-frame with reads in flight
        wbn = 2'd2; lat = 5; wprob = 0; rdy_mode = 2;
        pulse_fs();
        for (int i = 0; i < 500 && cmd_i < 30; i++) @(posedge clk);
        #1;
        chk("t5_reached_30", cmd_i >= 30, 1);
        wbn = 2'd1;
        pulse_fs();
        chk("t5_in_drain", mode == M_DRAIN, 1);
        chk("t5_owed_nonzero", owed > 0, 1);
        chk("t5_no_pix_in_drain", pv, 0);
        wait_done();
        chk("t5_rbn", rbn, 0);
        chk("t5_pops", pop_i, 64);
        chk("t5_uf_pre", uf, 0);

        // Stalled slave with ready consumer: sticky underflow, then reset mid-frame
        wbn = 2'd1; lat = 1; wprob = 100; rdy_mode = 1;
        pulse_fs();
        repeat (20) @(posedge clk);
        #1;
        chk("t6_uf_set", uf, 1);
        chk("t6_stall_read", rd, 1);
        wprob = 0;
        repeat (30) @(posedge clk);
        #1;
        chk("t6_uf_sticky", uf, 1);
        chk("t6_midframe", cmd_i > 0 && pop_i < FW, 1);
        rest_n = 0;
        #1;
        chk_reset("t6_rst");
        repeat (2) @(posedge clk);
        #1 rest_n = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_idle_after_rst", rd, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1);
    end

endmodule
